dut_multiplier_tiled_seq: RTL and testbench

Iterative, parametrised WIDTH x WIDTH multiplier. It reuses a single 9x9 combinational tile (dut_multiplier_9x9_comb) over (WIDTH/9)^2 cycles instead of instantiating all tiles in parallel. Adds a signed/unsigned mode and valid/ready handshakes on input and output. It is the area-optimised successor to the fully combinational 18x18 multiplier and sits in the same DUT datapath.

---
 rtl/dut_multiplier_tiled_seq_pkg.sv | 51 +++++
 rtl/dut_multiplier_tiled_seq_9x9_comb.sv | 21 ++
 rtl/dut_multiplier_tiled_seq.sv | 172 +++++++++++++++++
 tb/tb_dut_multiplier_tiled_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dut_multiplier_tiled_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dut_multiplier_pkg
// Purpose  : Shared constants, FSM state type and operand-magnitude helper
//            for the tiled sequential multiplier.
// Contents : TILE_W    - width of one multiplier tile (9 bits)
//            PROD_W    - width of one tile product (18 bits)
//            MAX_W     - widest operand the magnitude helper can process
//            state_t   - IDLE / BUSY / DONE
//            operand_magnitude() - WIDTH-bit magnitude and sign of an operand
// Revision : 1.0 - initial release
// ============================================================================
package dut_multiplier_pkg;

   localparam int TILE_W = 9;
   localparam int PROD_W = 2 * TILE_W;
   localparam int MAX_W  = 288;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic             neg;
      logic [MAX_W-1:0] mag;
   } operand_mag_t;

   // x holds the operand zero-extended to MAX_W bits; only the low 'width'
   // bits are meaningful. In signed mode a negative operand is negated over
   // the full vector and then masked back to 'width' bits, which yields the
   // correct unsigned magnitude, including 2^(width-1) for the most-negative
   // value. Bits at and above 'width' of the returned magnitude are zero.
   function automatic operand_mag_t operand_magnitude(
      input logic [MAX_W-1:0] x,
      input int unsigned      width,
      input logic             is_signed
   );
      operand_mag_t     r;
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] msb_bit;
      mask    = {MAX_W{1'b1}} >> (MAX_W - width);
      msb_bit = MAX_W'(1) << (width - 1);
      r.neg   = is_signed & (|(x & msb_bit));
      r.mag   = (r.neg ? (~x + MAX_W'(1)) : x) & mask;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dut_multiplier_tiled_seq_9x9_comb.sv
`default_nettype none
// ============================================================================
// Module   : dut_multiplier_9x9_comb
// Purpose  : Purely combinational 9x9 unsigned multiplier tile.
// Ports    : i_a       [8:0]  in   multiplicand tile
//            i_b       [8:0]  in   multiplier tile
//            o_product [17:0] out  unsigned product
// Revision : 1.0 - initial release
// ============================================================================
module dut_multiplier_9x9_comb
   import dut_multiplier_pkg::*;
(
   input  logic [TILE_W-1:0] i_a,
   input  logic [TILE_W-1:0] i_b,
   output logic [PROD_W-1:0] o_product
);

   assign o_product = PROD_W'(i_a) * PROD_W'(i_b);

endmodule
`default_nettype wire

// File: rtl/dut_multiplier_tiled_seq.sv
`default_nettype none
// ============================================================================
// Module   : dut_multiplier_tiled_seq
// Purpose  : Iterative WIDTH x WIDTH multiplier that reuses one 9x9 tile over
//            (WIDTH/9)^2 cycles. Signed or unsigned operands, valid/ready
//            handshakes on both sides, at most one operation in flight.
// Ports    : clk          in   clock, rising edge
//            rst          in   asynchronous reset, active-high
//            VDD, VSS     in   power pins, no functional use
//            in_valid     in   operand request
//            in_ready     out  block can accept operands
//            a, b         in   operands [WIDTH-1:0]
//            signed_mode  in   1 = two's complement, 0 = unsigned
//            out_valid    out  result available
//            out_ready    in   consumer accepts result
//            result       out  registered product [2*WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module dut_multiplier_tiled_seq
   import dut_multiplier_pkg::*;
#(
   parameter int WIDTH = 18
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               VDD,
   input  logic               VSS,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result
);

   localparam int N_TILES = WIDTH / TILE_W;
   localparam int c_acc_w = 2 * WIDTH;
   localparam int c_idx_w = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_TILES - 1);

   generate
      if ((WIDTH < TILE_W) || ((WIDTH % TILE_W) != 0) || (WIDTH >= MAX_W)) begin : g_width_check
         $error("dut_multiplier_tiled_seq: WIDTH must be a multiple of 9, >= 9 and below MAX_W");
      end
   endgenerate

   // ---------------------------------------------------------------- state
   state_t               r_state;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [c_acc_w-1:0]   r_result;
   logic [c_acc_w-1:0]   r_acc;
   logic [WIDTH-1:0]     r_a_mag;
   logic [WIDTH-1:0]     r_b_mag;
   logic                 r_neg;
   logic [c_idx_w-1:0]   r_i;        // a tile index, inner loop
   logic [c_idx_w-1:0]   r_j;        // b tile index, outer loop

   // ------------------------------------------------------ operand capture
   operand_mag_t w_a_op;
   operand_mag_t w_b_op;

   assign w_a_op = operand_magnitude(MAX_W'(a), WIDTH, signed_mode);
   assign w_b_op = operand_magnitude(MAX_W'(b), WIDTH, signed_mode);

   // ---------------------------------------------------------- tile select
   logic [TILE_W-1:0] w_a_tiles [N_TILES];
   logic [TILE_W-1:0] w_b_tiles [N_TILES];
   logic [TILE_W-1:0] w_a_tile;
   logic [TILE_W-1:0] w_b_tile;
   logic [PROD_W-1:0] w_pp;

   for (genvar t = 0; t < N_TILES; t++) begin : g_tiles
      assign w_a_tiles[t] = r_a_mag[t*TILE_W +: TILE_W];
      assign w_b_tiles[t] = r_b_mag[t*TILE_W +: TILE_W];
   end

   assign w_a_tile = w_a_tiles[r_i];
   assign w_b_tile = w_b_tiles[r_j];

   dut_multiplier_9x9_comb u_tile (
      .i_a       (w_a_tile),
      .i_b       (w_b_tile),
      .o_product (w_pp)
   );

   // ------------------------------------------------------- accumulation
   // Partial product weighted by 2^(9*(i+j)); the running sum of all
   // partial products never exceeds the full 2*WIDTH-bit product.
   logic [c_acc_w-1:0] w_pp_shift;
   logic [c_acc_w-1:0] w_sum;
   logic               w_last;

   assign w_pp_shift = c_acc_w'(w_pp) << (TILE_W * (int'(r_i) + int'(r_j)));
   assign w_sum      = r_acc + w_pp_shift;
   assign w_last     = (r_i == c_last_idx) && (r_j == c_last_idx);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_acc       <= '0;
         r_a_mag     <= '0;
         r_b_mag     <= '0;
         r_neg       <= 1'b0;
         r_i         <= '0;
         r_j         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_mag    <= w_a_op.mag[WIDTH-1:0];
                  r_b_mag    <= w_b_op.mag[WIDTH-1:0];
                  r_neg      <= w_a_op.neg ^ w_b_op.neg;
                  r_acc      <= '0;
                  r_i        <= '0;
                  r_j        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               if (w_last) begin
                  // A zero magnitude negates to zero, so neg needs no guard.
                  r_result    <= r_neg ? (-w_sum) : w_sum;
                  r_acc       <= '0;
                  r_i         <= '0;
                  r_j         <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_acc <= w_sum;
                  if (r_i == c_last_idx) begin
                     r_i <= '0;
                     r_j <= r_j + c_idx_w'(1);
                  end else begin
                     r_i <= r_i + c_idx_w'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;

   // Power pins and the always-zero upper magnitude bits carry no function.
   logic w_unused;
   assign w_unused = ^{VDD, VSS, w_a_op.mag[MAX_W-1:WIDTH], w_b_op.mag[MAX_W-1:WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_dut_multiplier_tiled_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dut_multiplier_tiled_seq
// Purpose  : Self-checking bench for dut_multiplier_tiled_seq (WIDTH=18 and
//            WIDTH=27 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dut_multiplier_tiled_seq;

   localparam int W  = 18;
   localparam int W2 = 27;

   logic clk = 1'b0;
   logic rst;
   logic vdd = 1'b1;
   logic vss = 1'b0;

   logic            in_valid, in_ready, signed_mode, out_valid, out_ready;
   logic [W-1:0]    a, b;
   logic [2*W-1:0]  result;

   logic            in_valid27, in_ready27, signed_mode27, out_valid27, out_ready27;
   logic [W2-1:0]   a27, b27;
   logic [2*W2-1:0] result27;

   always #5 clk = ~clk;

   dut_multiplier_tiled_seq #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(rst), .VDD(vdd), .VSS(vss),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .result(result)
   );

   dut_multiplier_tiled_seq #(.WIDTH(W2)) u_dut27 (
      .clk(clk), .rst(rst), .VDD(vdd), .VSS(vss),
      .in_valid(in_valid27), .in_ready(in_ready27), .a(a27), .b(b27),
      .signed_mode(signed_mode27), .out_valid(out_valid27),
      .out_ready(out_ready27), .result(result27)
   );

   int errors = 0;
   int checks = 0;
   logic [2*W-1:0] sb_q[$];

   typedef struct {
      logic [W-1:0]   va;
      logic [W-1:0]   vb;
      logic           vsm;
      logic [2*W-1:0] vexp;
      int             hold;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref18(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sm);
      logic signed [2*W-1:0] sx, sy;
      if (sm) begin
         sx = {{W{x[W-1]}}, x};
         sy = {{W{y[W-1]}}, y};
         return sx * sy;
      end
      return {{W{1'b0}}, x} * {{W{1'b0}}, y};
   endfunction

   function automatic logic [W-1:0] pick18();
      case ($urandom_range(0, 7))
         0:       return 18'h00000;
         1:       return 18'h00001;
         2:       return 18'h3FFFF;
         3:       return 18'h20000;
         4:       return 18'h1FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   // One complete operation on the 18-bit instance: acceptance, latency,
   // optional backpressure hold, output handshake and release.
   task automatic do_op18(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsm,
                          input logic [2*W-1:0] vexp, input int gap, input int hold,
                          input string tag);
      int             lat;
      int             bad;
      logic [2*W-1:0] snap;
      in_valid = 1'b0;
      repeat (gap) step();
      a = va; b = vb; signed_mode = vsm; in_valid = 1'b1;
      lat = 0;
      while (!in_ready && lat < 50) begin step(); lat++; end
      if (!in_ready) begin
         chk({tag, " accept_timeout"}, 64'(in_ready), 64'(1));
         in_valid = 1'b0;
         return;
      end
      step();
      sb_q.push_back(vexp);
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin step(); lat++; end
      chk({tag, " latency"}, 64'(lat), 64'(4));
      if (!out_valid) return;
      snap = result;
      bad  = 0;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         a = W'($urandom); b = W'($urandom);
         step();
         if (!out_valid || in_ready || result !== snap) bad++;
      end
      in_valid = 1'b0;
      if (hold > 0) chk({tag, " hold_stable"}, 64'(bad), 64'(0));
      out_ready = 1'b1;
      if (sb_q.size() > 0) chk({tag, " result"}, 64'(result), 64'(sb_q.pop_front()));
      step();
      out_ready = 1'b0;
      chk({tag, " post_handshake"}, {62'd0, out_valid, in_ready}, 64'(1));
   endtask

   task automatic do_op27(input logic [W2-1:0] va, input logic [W2-1:0] vb, input logic vsm,
                          input logic [2*W2-1:0] vexp, input string tag);
      int lat;
      a27 = va; b27 = vb; signed_mode27 = vsm; in_valid27 = 1'b1;
      lat = 0;
      while (!in_ready27 && lat < 50) begin step(); lat++; end
      step();
      in_valid27 = 1'b0;
      a27 = '0; b27 = '0;
      lat = 0;
      while (!out_valid27 && lat < 50) begin step(); lat++; end
      chk({tag, " latency"}, 64'(lat), 64'(9));
      out_ready27 = 1'b1;
      chk({tag, " result"}, 64'(result27), 64'(vexp));
      step();
      out_ready27 = 1'b0;
   endtask

   initial begin
      int lat;
      int stale;
      logic [W-1:0] ra, rb;
      logic         rsm;

      vecs[0]  = '{18'h3FFFF, 18'h3FFFF, 1'b0, 36'hFFFF80001, 10};
      vecs[1]  = '{18'h3FFFF, 18'h00003, 1'b1, 36'hFFFFFFFFD, 0};
      vecs[2]  = '{18'h20000, 18'h20000, 1'b1, 36'h400000000, 0};
      vecs[3]  = '{18'h00005, 18'h00007, 1'b0, 36'h000000023, 0};
      vecs[4]  = '{18'h00000, 18'h3FFFF, 1'b0, 36'h000000000, 0};
      vecs[5]  = '{18'h00000, 18'h20000, 1'b1, 36'h000000000, 0};
      vecs[6]  = '{18'h20000, 18'h00001, 1'b1, 36'hFFFFE0000, 0};
      vecs[7]  = '{18'h1FFFF, 18'h1FFFF, 1'b1, 36'h3FFFC0001, 0};
      vecs[8]  = '{18'h20000, 18'h00002, 1'b0, 36'h000040000, 3};
      vecs[9]  = '{18'h3FFFF, 18'h3FFFF, 1'b1, 36'h000000001, 0};
      vecs[10] = '{18'h1FFFF, 18'h3FFFF, 1'b1, 36'hFFFFE0001, 0};
      vecs[11] = '{18'h3FE00, 18'h001FF, 1'b0, 36'h007F80200, 0};
      vecs[12] = '{18'h3FFFF, 18'h20000, 1'b1, 36'h000020000, 0};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
      in_valid27 = 1'b0; out_ready27 = 1'b0; a27 = '0; b27 = '0; signed_mode27 = 1'b0;
      repeat (3) step();
      chk("reset state", {61'd0, in_ready, out_valid, |result}, 64'(4));
      rst = 1'b0;
      step();

      // Table vectors (vector 0 also exercises 10-cycle backpressure).
      foreach (vecs[k])
         do_op18(vecs[k].va, vecs[k].vb, vecs[k].vsm, vecs[k].vexp, 0, vecs[k].hold,
                 $sformatf("vec%0d", k));

      // Reset two cycles into an operation discards it.
      a = 18'h12345; b = 18'h0ABCD; signed_mode = 1'b0; in_valid = 1'b1;
      lat = 0;
      while (!in_ready && lat < 50) begin step(); lat++; end
      step();
      in_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      #1;
      chk("midop reset", {61'd0, in_ready, out_valid, |result}, 64'(4));
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      repeat (12) begin step(); if (out_valid) stale++; end
      out_ready = 1'b0;
      chk("no stale out_valid", 64'(stale), 64'(0));
      do_op18(18'd5, 18'd7, 1'b0, 36'd35, 0, 0, "after_reset");

      // WIDTH=27 instance.
      do_op27(27'h7FFFFFF, 27'h0000002, 1'b0, 54'h00000000FFFFFFE, "w27 unsigned");
      do_op27(27'h4000000, 27'h7FFFFFF, 1'b1, 54'h000000004000000, "w27 minneg_x_m1");
      do_op27(27'h4000000, 27'h3FFFFFF, 1'b1, 54'h30000004000000, "w27 minneg_x_max");

      // Random operations with corner injection, gaps and backpressure.
      for (int n = 0; n < 400; n++) begin
         ra  = pick18();
         rb  = pick18();
         rsm = 1'($urandom);
         do_op18(ra, rb, rsm, ref18(ra, rb, rsm), $urandom_range(0, 2),
                 $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end

      chk("scoreboard drained", 64'(sb_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
